// File: rtl/keypad_if.sv
// Keypad scanner bus: matrix rows/columns plus the decoded key outputs.
//   row       4  keypad rows, active-low (into scanner)
//   col       4  keypad columns, active-low one-hot (from scanner)
//   key_code  4  code of the last accepted key
//   key_valid 1  one-clk pulse when key_code is updated
//   key_held  1  debounced key-pressed level
//   nums      16 {BCD4,BCD3,BCD2,BCD1} for the 7-segment driver
// master = scanner side, slave = keypad/display side.
interface keypad_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] nums;

  modport master (input row, output col, key_code, key_valid, key_held, nums);
  modport slave  (output row, input col, key_code, key_valid, key_held, nums);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounce, ghost rejection and a
// scrolling 4-digit nums register for the 7-segment driver.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   kp   keypad_if.master (row in; col, key_code, key_valid, key_held, nums out)
// Optional feature: define KEYPAD_REPEAT_EN to re-issue key_valid every
// REPEAT_SCANS full scans while the accepted key stays held.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 32768,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 64
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned REP_W = $clog2(REPEAT_SCANS + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1)
  begin : g_cfg_err
    $error("keypad_scanner: illegal parameter value");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_PRESSED = 1'b1} state_e;

  // Matrix position (row*4+col) to key code.
  function automatic logic [3:0] key_to_code(input logic [3:0] k);
    logic [3:0] c;
    case (k)
      4'd0:  c = 4'd1;   4'd1:  c = 4'd2;   4'd2:  c = 4'd3;   4'd3:  c = 4'd12;
      4'd4:  c = 4'd4;   4'd5:  c = 4'd5;   4'd6:  c = 4'd6;   4'd7:  c = 4'd13;
      4'd8:  c = 4'd7;   4'd9:  c = 4'd8;   4'd10: c = 4'd9;   4'd11: c = 4'd14;
      4'd12: c = 4'd10;  4'd13: c = 4'd0;   4'd14: c = 4'd11;  default: c = 4'd15;
    endcase
    return c;
  endfunction

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       low_cnt_q, low_cnt_d;
  logic [3:0]       key_acc_q, key_acc_d;
  logic             cand_none_q, cand_none_d;
  logic [3:0]       cand_key_q, cand_key_d;
  logic [3:0]       db_cnt_q, db_cnt_d;
  state_e           state_q, state_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic [15:0]      nums_q, nums_d;
`ifdef KEYPAD_REPEAT_EN
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  // Per-sample decode of the synchronized rows for the current column.
  logic       tick_c;
  logic [3:0] lows_c;
  logic [2:0] n_low_c, low_tot_c;
  logic [1:0] row_idx_c, low_sat_c;
  logic [3:0] key_here_c;

  always_comb begin
    tick_c     = (div_q == DIV_W'(SCAN_DIV - 1));
    lows_c     = ~row_sync_q;
    n_low_c    = 3'(lows_c[0]) + 3'(lows_c[1]) + 3'(lows_c[2]) + 3'(lows_c[3]);
    row_idx_c  = 2'd0;
    case (lows_c)
      4'b0010: row_idx_c = 2'd1;
      4'b0100: row_idx_c = 2'd2;
      4'b1000: row_idx_c = 2'd3;
      default: row_idx_c = 2'd0;
    endcase
    // Column 0 opens a new scan, so the running low count restarts there.
    low_tot_c  = ((col_idx_q == 2'd0) ? 3'd0 : 3'(low_cnt_q)) + n_low_c;
    low_sat_c  = (low_tot_c >= 3'd2) ? 2'd2 : low_tot_c[1:0];
    key_here_c = {row_idx_c, col_idx_q};
  end

  // Scan sequencing, debounce and IDLE/PRESSED key FSM.
  always_comb begin
    logic       res_none;
    logic [3:0] res_key;
    logic       stable;
    logic       fire;

    div_d       = div_q + DIV_W'(1);
    col_d       = col_q;
    col_idx_d   = col_idx_q;
    low_cnt_d   = low_cnt_q;
    key_acc_d   = key_acc_q;
    cand_none_d = cand_none_q;
    cand_key_d  = cand_key_q;
    db_cnt_d    = db_cnt_q;
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    nums_d      = nums_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif
    res_none    = 1'b1;
    res_key     = 4'd0;
    stable      = 1'b0;
    fire        = 1'b0;

    if (tick_c) begin
      div_d     = '0;
      col_d     = {col_q[2:0], col_q[3]};
      col_idx_d = col_idx_q + 2'd1;
      low_cnt_d = low_sat_c;
      if (n_low_c == 3'd1) key_acc_d = key_here_c;

      if (col_idx_q == 2'd3) begin
        // Exactly one low across the whole scan is a key; anything else is NONE.
        res_none = (low_sat_c != 2'd1);
        res_key  = res_none ? 4'd0 : ((n_low_c == 3'd1) ? key_here_c : key_acc_q);

        if (res_none == cand_none_q && res_key == cand_key_q) begin
          db_cnt_d = (db_cnt_q >= 4'(DEBOUNCE_SCANS)) ? 4'(DEBOUNCE_SCANS) : db_cnt_q + 4'd1;
        end else begin
          db_cnt_d    = 4'd1;
          cand_none_d = res_none;
          cand_key_d  = res_key;
        end
        stable = (db_cnt_d == 4'(DEBOUNCE_SCANS));

        case (state_q)
          ST_IDLE: begin
            if (stable && !cand_none_d) begin
              state_d    = ST_PRESSED;
              key_code_d = key_to_code(cand_key_d);
              key_held_d = 1'b1;
              fire       = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_d      = '0;
`endif
            end
          end
          ST_PRESSED: begin
            if (stable && cand_none_d) begin
              state_d    = ST_IDLE;
              key_held_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
              rep_d      = '0;
            end else if (stable && key_to_code(cand_key_d) == key_code_q) begin
              if (rep_q == REP_W'(REPEAT_SCANS - 1)) begin
                rep_d = '0;
                fire  = 1'b1;
              end else begin
                rep_d = rep_q + REP_W'(1);
              end
`endif
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // Accepted (or repeated) key scrolls into the display.
    if (fire) begin
      key_valid_d = 1'b1;
      if (key_code_d <= 4'd9 || key_code_d == 4'd11) begin
        nums_d = {nums_q[11:0], key_code_d};
      end else if (key_code_d == 4'd10) begin
        nums_d = 16'hFFFF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      div_q       <= '0;
      col_q       <= 4'b1110;
      col_idx_q   <= 2'd0;
      low_cnt_q   <= 2'd0;
      key_acc_q   <= 4'd0;
      cand_none_q <= 1'b1;
      cand_key_q  <= 4'd0;
      db_cnt_q    <= 4'd0;
      state_q     <= ST_IDLE;
      key_code_q  <= 4'hF;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      nums_q      <= 16'hFFFF;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      row_meta_q  <= kp.row;
      row_sync_q  <= row_meta_q;
      div_q       <= div_d;
      col_q       <= col_d;
      col_idx_q   <= col_idx_d;
      low_cnt_q   <= low_cnt_d;
      key_acc_q   <= key_acc_d;
      cand_none_q <= cand_none_d;
      cand_key_q  <= cand_key_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      nums_q      <= nums_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.nums      = nums_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: scan-level reference model driven by directed and
// $urandom keypad patterns; a matrix model shorts pressed keys' row to column.
module tb_keypad_scanner;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 2;
  localparam int unsigned REP      = 3;

  logic        clk;
  logic        rst;
  logic [15:0] pressed;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pulses_total = 0;
  int          p0;
  string       keymap = "123A456B789C*0#D";

  // Reference model state (one update per full scan).
  int          hist[$];
  bit          m_held;
  logic [3:0]  m_code;
  logic [15:0] m_nums;
  int          m_conf;

  keypad_if kp ();

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    kp.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp.col[c] && pressed[r*4+c]) kp.row[r] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] code_of(input int idx);
    byte ch;
    ch = keymap.getc(idx);
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    if (ch == "*") return 4'd10;
    if (ch == "#") return 4'd11;
    return 4'(ch - "A" + 12);
  endfunction

  function automatic void model_nums(input logic [3:0] code);
    if (code <= 4'd9 || code == 4'd11) m_nums = {m_nums[11:0], code};
    else if (code == 4'd10) m_nums = 16'hFFFF;
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_held = 1'b0;
    m_code = 4'hF;
    m_nums = 16'hFFFF;
    m_conf = 0;
  endfunction

  // One full scan with a fixed set of pressed keys; returns whether key_valid is due.
  function automatic bit model_scan(input logic [15:0] pat);
    int res;
    bit st;
    bit pulse;
    res   = -1;
    pulse = 1'b0;
    if ($countones(pat) == 1)
      for (int i = 0; i < 16; i++) if (pat[i]) res = i;
    hist.push_back(res);
    if (hist.size() > DEB) void'(hist.pop_front());
    st = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != res) st = 1'b0;
    if (!m_held) begin
      if (st && res >= 0) begin
        m_held = 1'b1;
        m_code = code_of(res);
        m_conf = 0;
        pulse  = 1'b1;
        model_nums(m_code);
      end
    end else if (st && res < 0) begin
      m_held = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    end else if (st && code_of(res) == m_code) begin
      m_conf++;
      if (m_conf % REP == 0) begin
        pulse = 1'b1;
        model_nums(m_code);
      end
`endif
    end
    return pulse;
  endfunction

  task automatic do_scan(input logic [15:0] pat);
    bit          ep;
    logic [15:0] kv_mask;
    logic [3:0]  ecol;
    pressed = pat;
    ep      = model_scan(pat);
    kv_mask = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (kp.key_valid) begin
        kv_mask[i-1] = 1'b1;
        pulses_total++;
      end
      ecol = ~(4'b0001 << ((i / 4) % 4));
      check_eq("col", 32'(kp.col), 32'(ecol));
    end
    check_eq("key_valid_pos", 32'(kv_mask), ep ? 32'h8000 : 32'h0);
    check_eq("key_held", 32'(kp.key_held), 32'(m_held));
    check_eq("key_code", 32'(kp.key_code), 32'(m_code));
    check_eq("nums", 32'(kp.nums), 32'(m_nums));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_col", 32'(kp.col), 32'h0000000E);
    check_eq("rst_held", 32'(kp.key_held), 32'h0);
    check_eq("rst_valid", 32'(kp.key_valid), 32'h0);
    check_eq("rst_code", 32'(kp.key_code), 32'hF);
    check_eq("rst_nums", 32'(kp.nums), 32'hFFFF);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_partial(input int n);
    int kv;
    kv = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (kp.key_valid) kv++;
    end
    check_eq("partial_valid", 32'(kv), 32'h0);
  endtask

  task automatic press(input int idx);
    logic [15:0] pat;
    pat = '0;
    pat[idx] = 1'b1;
    repeat (3) do_scan(pat);
    repeat (3) do_scan(16'h0);
  endtask

  initial begin
    rst     = 1'b1;
    pressed = '0;
    model_reset();
    do_reset();

    // Column rotation with nothing pressed.
    repeat (2) do_scan(16'h0);

    // '5' held for 3 scans, then released.
    p0 = pulses_total;
    repeat (3) do_scan(16'h0020);
    check_eq("t2_pulses", 32'(pulses_total - p0), 32'd1);
    check_eq("t2_code", 32'(kp.key_code), 32'd5);
    check_eq("t2_nums", 32'(kp.nums), 32'hFFF5);
    do_scan(16'h0);
    check_eq("t2_held_1scan", 32'(kp.key_held), 32'd1);
    do_scan(16'h0);
    check_eq("t2_held_2scan", 32'(kp.key_held), 32'd0);
    do_scan(16'h0);

    // Digits 1,2,3,4,7 then '*' then '#'.
    press(0); press(1); press(2); press(4); press(8);
    check_eq("t3_nums_2347", 32'(kp.nums), 32'h2347);
    press(12);
    check_eq("t3_nums_clear", 32'(kp.nums), 32'hFFFF);
    press(14);
    check_eq("t3_nums_dash", 32'(kp.nums), 32'hFFFB);

    // '8' bouncing at scan rate, then stable.
    p0 = pulses_total;
    do_scan(16'h0200); do_scan(16'h0); do_scan(16'h0200); do_scan(16'h0);
    repeat (3) do_scan(16'h0200);
    repeat (3) do_scan(16'h0);
    check_eq("t4_pulses", 32'(pulses_total - p0), 32'd1);
    check_eq("t4_code", 32'(kp.key_code), 32'd8);

    // Ghost '1'+'5' rejected, then 'A' accepted without touching nums.
    p0 = pulses_total;
    repeat (3) do_scan(16'h0021);
    repeat (3) do_scan(16'h0);
    check_eq("t5_ghost_pulses", 32'(pulses_total - p0), 32'd0);
    check_eq("t5_ghost_nums", 32'(kp.nums), 32'hFFB8);
    press(3);
    check_eq("t5_code_A", 32'(kp.key_code), 32'd12);
    check_eq("t5_nums_A", 32'(kp.nums), 32'hFFB8);

    // '9' held for 11 scans, then reset mid-hold.
    do_reset();
    p0 = pulses_total;
    repeat (11) do_scan(16'h0400);
`ifdef KEYPAD_REPEAT_EN
    check_eq("t6_pulses", 32'(pulses_total - p0), 32'd4);
    check_eq("t6_nums", 32'(kp.nums), 32'h9999);
`else
    check_eq("t6_pulses", 32'(pulses_total - p0), 32'd1);
    check_eq("t6_nums", 32'(kp.nums), 32'hFFF9);
`endif
    do_partial(7);
    do_reset();
    p0 = pulses_total;
    repeat (2) do_scan(16'h0400);
    check_eq("t6_fresh_pulse", 32'(pulses_total - p0), 32'd1);
    check_eq("t6_fresh_held", 32'(kp.key_held), 32'd1);
    check_eq("t6_fresh_nums", 32'(kp.nums), 32'hFFF9);
    repeat (3) do_scan(16'h0);

    // Random keypad activity at scan granularity.
    for (int seg = 0; seg < 40; seg++) begin
      logic [15:0] pat;
      int kind, k1, k2, len;
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 4);
      k1   = $urandom_range(0, 15);
      k2   = (k1 + $urandom_range(1, 15)) % 16;
      pat  = '0;
      if (kind != 0) pat[k1] = 1'b1;
      if (kind == 3) pat[k2] = 1'b1;
      repeat (len) do_scan(pat);
    end
    repeat (3) do_scan(16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
